// File: rtl/dmem_port_arbiter_pkg.sv
// dmem_port_arbiter_pkg: shared types for the data-memory port arbiter
package dmem_port_arbiter_pkg;
  typedef enum logic {OWN_C, OWN_B} owner_t;
  typedef enum logic {RR, LOCKED} arb_state_t;
endpackage

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares one data-memory port between core (C) and bootloader (B)
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_HOLD   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    c_req,
  input  logic                    c_we,
  input  logic [DATA_WIDTH/8-1:0] c_be,
  input  logic [ADDR_WIDTH-1:0]   c_addr,
  input  logic [DATA_WIDTH-1:0]   c_wdata,
  output logic                    c_gnt,
  output logic                    c_rvalid,
  output logic [DATA_WIDTH-1:0]   c_rdata,
  input  logic                    b_req,
  input  logic                    b_we,
  input  logic [DATA_WIDTH/8-1:0] b_be,
  input  logic [ADDR_WIDTH-1:0]   b_addr,
  input  logic [DATA_WIDTH-1:0]   b_wdata,
  output logic                    b_gnt,
  output logic                    b_rvalid,
  output logic [DATA_WIDTH-1:0]   b_rdata,
  input  logic                    b_lock,
  output logic                    mem_en,
  output logic                    mem_we,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_din,
  input  logic [DATA_WIDTH-1:0]   mem_dout
);
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HMAX = HW'(MAX_HOLD);
  localparam logic [HW-1:0] HONE = HW'(1);
  arb_state_t state, state_nx;
  owner_t last_gnt, rd_own;
  logic [HW-1:0] hold_cnt, hold_nx;
  logic rd_pend, force_c;
  // grant selection, memory mux, read-data steering and next-state
  always_comb begin
    force_c  = state == LOCKED && c_req && hold_cnt == HMAX;
    b_gnt    = state == LOCKED ? b_req && !force_c : b_req && !(c_req && last_gnt == OWN_B);
    c_gnt    = c_req && !b_gnt;
    mem_en   = c_gnt || b_gnt;
    mem_we   = c_gnt ? c_we : b_gnt && b_we;
    mem_be   = c_gnt ? c_be : b_gnt ? b_be : '0;
    mem_addr = c_gnt ? c_addr : b_gnt ? b_addr : '0;
    mem_din  = c_gnt ? c_wdata : b_gnt ? b_wdata : '0;
    c_rvalid = rd_pend && rd_own == OWN_C;
    b_rvalid = rd_pend && rd_own == OWN_B;
    c_rdata  = c_rvalid ? mem_dout : '0;
    b_rdata  = b_rvalid ? mem_dout : '0;
    state_nx = state == LOCKED ? (b_lock ? LOCKED : RR) : (b_gnt && b_lock ? LOCKED : RR);
    hold_nx  = state == RR ? (b_gnt && b_lock && c_req ? HONE : '0)
             : !b_lock || force_c ? '0
             : b_gnt && c_req && hold_cnt != HMAX ? hold_cnt + HONE : hold_cnt;
  end
  // arbitration state, starvation counter and one-cycle read tracker
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state    <= RR;
      last_gnt <= OWN_B;
      hold_cnt <= '0;
      rd_pend  <= 1'b0;
      rd_own   <= OWN_C;
    end else begin
      state    <= state_nx;
      hold_cnt <= hold_nx;
      if (mem_en) last_gnt <= b_gnt ? OWN_B : OWN_C;
      rd_pend  <= mem_en && !mem_we;
      rd_own   <= b_gnt ? OWN_B : OWN_C;
    end
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: directed and randomized check of dmem_port_arbiter against a reference model
module tb_dmem_port_arbiter;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int MH = 4;
  logic clk = 1'b0;
  logic rst;
  logic c_req, c_we, c_gnt, c_rvalid;
  logic [BW-1:0] c_be;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_wdata, c_rdata;
  logic b_req, b_we, b_gnt, b_rvalid, b_lock;
  logic [BW-1:0] b_be;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_wdata, b_rdata;
  logic mem_en, mem_we;
  logic [BW-1:0] mem_be;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic [DW-1:0] mem_dout = '0;
  logic [DW-1:0] env_mem [1024] = '{5: 32'hDEADBEEF, default: 32'hA5C30F96};
  logic [DW-1:0] ref_mem [1024] = '{5: 32'hDEADBEEF, default: 32'hA5C30F96};
  int total = 0;
  int passed = 0;
  bit m_locked, m_last_b, m_rv_c, m_rv_b;
  int m_streak;
  logic [DW-1:0] m_rdata;
  bit g_c, g_b, d_c, d_b;
  int run, maxrun, nc;

  always #5 clk = ~clk;

  dmem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_HOLD(MH)) dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_be(c_be), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .b_req(b_req), .b_we(b_we), .b_be(b_be), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata), .b_lock(b_lock),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout)
  );

  // single-port synchronous memory with one-cycle read latency
  always @(posedge clk)
    if (mem_en) begin
      if (mem_we) begin
        for (int k = 0; k < BW; k++) if (mem_be[k]) env_mem[mem_addr][8*k +: 8] <= mem_din[8*k +: 8];
      end else mem_dout <= env_mem[mem_addr];
    end

  task automatic chk(string tag, logic [DW-1:0] obs, logic [DW-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_locked = 0; m_last_b = 1; m_streak = 0; m_rv_c = 0; m_rv_b = 0; m_rdata = '0;
  endtask

  task automatic set_c(logic we, logic [BW-1:0] be, logic [AW-1:0] a, logic [DW-1:0] d);
    c_req = 1; c_we = we; c_be = be; c_addr = a; c_wdata = d;
  endtask

  task automatic set_b(logic we, logic [BW-1:0] be, logic [AW-1:0] a, logic [DW-1:0] d);
    b_req = 1; b_we = we; b_be = be; b_addr = a; b_wdata = d;
  endtask

  // called at a falling edge with inputs applied; checks this cycle, advances the model, waits a cycle
  task automatic step();
    logic ec, eb, we;
    logic [BW-1:0] be;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    #1;
    eb = b_req && (m_locked ? !(c_req && m_streak >= MH) : !(c_req && m_last_b));
    ec = c_req && !eb;
    we = ec ? c_we : eb ? b_we : 1'b0;
    be = ec ? c_be : eb ? b_be : '0;
    a  = ec ? c_addr : eb ? b_addr : '0;
    d  = ec ? c_wdata : eb ? b_wdata : '0;
    chk("c_gnt", DW'(c_gnt), DW'(ec));
    chk("b_gnt", DW'(b_gnt), DW'(eb));
    chk("mem_en", DW'(mem_en), DW'(ec || eb));
    chk("mem_we", DW'(mem_we), DW'(we));
    chk("mem_be", DW'(mem_be), DW'(be));
    chk("mem_addr", DW'(mem_addr), DW'(a));
    chk("mem_din", mem_din, d);
    chk("c_rvalid", DW'(c_rvalid), DW'(m_rv_c));
    chk("c_rdata", c_rdata, m_rv_c ? m_rdata : '0);
    chk("b_rvalid", DW'(b_rvalid), DW'(m_rv_b));
    chk("b_rdata", b_rdata, m_rv_b ? m_rdata : '0);
    d_c = c_gnt; d_b = b_gnt; g_c = ec; g_b = eb;
    if (!rst) begin
      m_rv_c = ec && !we;
      m_rv_b = eb && !we;
      m_rdata = ref_mem[a];
      if ((ec || eb) && we)
        for (int k = 0; k < BW; k++) if (be[k]) ref_mem[a][8*k +: 8] = d[8*k +: 8];
      if (ec || eb) m_last_b = eb;
      if (m_locked) begin
        if (!b_lock) begin m_locked = 0; m_streak = 0; end
        else if (c_req && m_streak >= MH) m_streak = 0;
        else if (eb && c_req) m_streak++;
      end else if (eb && b_lock) begin
        m_locked = 1;
        m_streak = c_req ? 1 : 0;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    c_req = 0; c_we = 0; c_be = '0; c_addr = '0; c_wdata = '0;
    b_req = 0; b_we = 0; b_be = '0; b_addr = '0; b_wdata = '0; b_lock = 0;
    rst = 1;
    model_reset();
    @(negedge clk);
    step(); step();
    rst = 0;
    step();
    // lone core read of 0x005
    set_c(1'b0, 4'hF, 10'h005, '0);
    step();
    chk("t1_gnt", DW'(d_c), DW'(1));
    chk("t1_rvalid", DW'(c_rvalid), DW'(1));
    chk("t1_rdata", c_rdata, 32'hDEADBEEF);
    chk("t1_b_rvalid", DW'(b_rvalid), DW'(0));
    c_req = 0;
    step();
    // continuous conflict without lock alternates, B first since C won last
    set_c(1'b0, 4'hF, 10'h001, '0);
    set_b(1'b0, 4'hF, 10'h002, '0);
    for (int k = 0; k < 8; k++) begin
      step();
      chk("t2_alt", DW'(d_b), DW'(k % 2 == 0));
    end
    // locked streaming: B at most MH in a row while C waits
    b_lock = 1; run = 0; maxrun = 0; nc = 0;
    for (int k = 0; k < 15; k++) begin
      step();
      if (d_b) run++;
      if (d_c) begin run = 0; nc++; end
      if (run > maxrun) maxrun = run;
    end
    chk("t3_starve", DW'(maxrun), DW'(MH));
    chk("t3_cgnts", DW'(nc), DW'(3));
    // lock released mid-stream: back to alternation
    b_lock = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("t4_alt", DW'(d_b), DW'(k % 2 == 0));
    end
    c_req = 0; b_req = 0;
    step();
    // partial core write then bootloader readback
    set_c(1'b1, 4'b0011, 10'h010, 32'h12345678);
    #1;
    chk("t5_we", DW'(mem_we), DW'(1));
    chk("t5_be", DW'(mem_be), DW'(4'b0011));
    step();
    c_req = 0;
    set_b(1'b0, 4'hF, 10'h010, '0);
    step();
    b_req = 0;
    chk("t5_b_rvalid", DW'(b_rvalid), DW'(1));
    chk("t5_b_rdata", b_rdata, 32'hA5C35678);
    step();
    // reset right after a bootloader read grant drops the pending data
    set_b(1'b0, 4'hF, 10'h020, '0);
    step();
    b_req = 0;
    rst = 1;
    model_reset();
    step();
    chk("t6_norv", DW'(b_rvalid), DW'(0));
    step();
    rst = 0;
    step();
    chk("t6_norv2", DW'(b_rvalid), DW'(0));
    set_c(1'b0, 4'hF, 10'h003, '0);
    set_b(1'b0, 4'hF, 10'h004, '0);
    #1;
    chk("t6_c_first", DW'(c_gnt), DW'(1));
    step();
    c_req = 0; b_req = 0;
    step();
    // randomized traffic with lock toggling
    for (int i = 0; i < 800; i++) begin
      if (!c_req && $urandom_range(0, 3) != 0)
        set_c(1'($urandom), 4'($urandom), 10'($urandom_range(0, 15)), $urandom);
      if (!b_req && $urandom_range(0, 3) != 0)
        set_b(1'($urandom), 4'($urandom), 10'($urandom_range(0, 15)), $urandom);
      if ($urandom_range(0, 15) == 0) b_lock = ~b_lock;
      step();
      if (g_c) c_req = 0;
      if (g_b) b_req = 0;
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
